inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//  Instruction queue between fetch (ICache + branch predictor) and the decode stage.
//  Buffers fetched {pc, inst, pre_taken, pre_addr, is_exception, exception_cause}
//  entries in program order and presents the oldest one to decode with valid/ready handshakes.
//  Decouples fetch stalls from decode stalls; flushed on branch mispredict or exception redirect.
// PARAMETERS
//  DEPTH      8   number of entries; power of 2, >= 2
//  PTR_W      3   log2(DEPTH); derived, do not override
// PORTS
//  clk              in   1      core clock, rising edge
//  rst_n            in   1      asynchronous, active-low reset
//  flush            in   1      discard all entries (redirect from backend)
//  in_valid         in   1      fetch presents an entry
//  in_ready         out  1      queue can accept an entry this cycle
//  in_pc            in   32     fetch PC
//  in_inst          in   32     instruction word
//  in_pre_taken     in   1      predictor: branch predicted taken
//  in_pre_addr      in   32     predictor: predicted target
//  in_is_exception  in   2      fetch-side exception flags
//  in_exc_cause     in   2x7    per-flag exception cause
//  out_valid        out  1      head entry valid toward decode
//  out_ready        in   1      decode consumes head this cycle
//  out_pc / out_inst / out_pre_taken / out_pre_addr / out_is_exception / out_exc_cause
//                   out  32/32/1/32/2/2x7   head entry fields
//  count            out  PTR_W+1  occupied entries
// BEHAVIOUR
//  - Reset (rst_n=0, async): head=tail=0, count=0, out_valid=0, in_ready=1;
//    all out_* data = 0. Storage contents are don't-care.
//  - Enqueue when in_valid & in_ready at posedge: write at tail, tail++ (mod DEPTH).
//  - Dequeue when out_valid & out_ready at posedge: head++ (mod DEPTH).
//  - in_ready = (count != DEPTH) | (out_valid & out_ready): full queue accepts if draining the same cycle.
//  - out_valid = (count != 0); out_* driven combinationally from storage[head].
//  - Latency: entry accepted at edge N is visible on out_* after edge N (1 cycle), empty queue.
//  - Simultaneous enq+deq: count unchanged; valid both at empty (no, count=0 -> no deq) and full.
//  - Pointers are PTR_W bits and wrap naturally; count is PTR_W+1 bits, never exceeds DEPTH.
//  - flush: synchronous, highest priority; at posedge head=tail=count=0, concurrent
//    enqueue and dequeue are both dropped. out_valid=0 the cycle after flush.
//  - in_ready/out_valid have no combinational dependence on in_valid.
//  - Fields carried verbatim; queue does not interpret exceptions or predictions.
//  - Entry with is_exception!=0 is queued and delivered like any other.
// CONFIGURATION
//  IFQ_BYPASS_EN defined: when count==0, in_valid=1, out_ready=1 and no flush, the
//   incoming entry passes straight to out_* in the same cycle (out_valid=1, zero latency)
//   and is not written to storage. Creates combinational in_* -> out_* path.
//  Not defined: no bypass; minimum 1-cycle latency; all out_* from storage only.
// STRUCTURE
//  - Shared package ifq_pkg: typedef ifq_entry_t {pc, inst, pre_taken, pre_addr,
//    is_exception, exc_cause}; constant EXC_CAUSE_W = 7 (shared with decode).
//  - Storage: ifq_entry_t array[DEPTH], inline; no sub-module (pointer logic is trivial).
// TESTING
//  1 Reset mid-stream: count=5, assert rst_n=0 -> count=0, out_valid=0, in_ready=1 immediately.
//  2 Fill: enqueue pc 0x1c000000..+0x1c (8 entries), out_ready=0 -> count=8, in_ready=0,
//    then out_ready=1 -> pcs drain in order 0x1c000000..0x1c00001c.
//  3 Full + simultaneous: count=8, in_valid=1, out_ready=1 -> in_ready=1, count stays 8, wrap ok.
//  4 Flush vs enqueue: count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0.
//  5 Field integrity: enq pre_taken=1, pre_addr=0x1c000100, is_exception=2'b01,
//    exc_cause[0]=7'h08 -> identical values on out_* at dequeue.
//  6 IFQ_BYPASS_EN: empty, in_valid=1, out_ready=1, in_pc=0x1c000040 -> out_pc=0x1c000040,
//    out_valid=1 same cycle, count stays 0; without macro out_valid rises next cycle.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue and its neighbours (decode).
// Provides the queued entry payload and the exception-cause width.
package ifq_pkg;

    localparam int unsigned EXC_CAUSE_W = 7;
    localparam int unsigned EXC_FLAGS   = 2;

    // One fetched instruction with its prediction and fetch-side exception info.
    typedef struct packed {
        logic [31:0]                            pc;
        logic [31:0]                            inst;
        logic                                   pre_taken;
        logic [31:0]                            pre_addr;
        logic [EXC_FLAGS-1:0]                   is_exception;
        logic [EXC_FLAGS-1:0][EXC_CAUSE_W-1:0]  exc_cause;
    } ifq_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Instruction queue between fetch and decode. Holds entries in program order
// and presents the oldest to decode through a valid/ready handshake.
// Optional feature: define IFQ_BYPASS_EN for a zero-latency empty-queue bypass.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous discard of all entries (highest priority)
//   in_valid/in_ready fetch-side handshake; in_* entry fields
//   out_valid/out_ready decode-side handshake; out_* head entry fields
//   count             number of occupied entries
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [31:0]                            in_pc,
    input  logic [31:0]                            in_inst,
    input  logic                                   in_pre_taken,
    input  logic [31:0]                            in_pre_addr,
    input  logic [EXC_FLAGS-1:0]                   in_is_exception,
    input  logic [EXC_FLAGS-1:0][EXC_CAUSE_W-1:0]  in_exc_cause,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [31:0]                            out_pc,
    output logic [31:0]                            out_inst,
    output logic                                   out_pre_taken,
    output logic [31:0]                            out_pre_addr,
    output logic [EXC_FLAGS-1:0]                   out_is_exception,
    output logic [EXC_FLAGS-1:0][EXC_CAUSE_W-1:0]  out_exc_cause,
    output logic [PTR_W:0]                         count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    ifq_entry_t       mem [DEPTH];
    ifq_entry_t       in_ent;
    ifq_entry_t       head_ent;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count_q;
    logic             stored_valid;
    logic             bypass;
    logic             do_enq;
    logic             do_deq;

    assign in_ent = '{pc:           in_pc,
                      inst:         in_inst,
                      pre_taken:    in_pre_taken,
                      pre_addr:     in_pre_addr,
                      is_exception: in_is_exception,
                      exc_cause:    in_exc_cause};

    assign stored_valid = (count_q != '0);

`ifdef IFQ_BYPASS_EN
    // Empty queue with a consumer waiting: hand the entry straight through.
    assign bypass = !stored_valid && in_valid && out_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    // stored_valid stands in for out_valid so in_ready never depends on in_valid.
    assign in_ready  = (count_q != FULL_CNT) || (stored_valid && out_ready);
    assign out_valid = stored_valid || bypass;
    assign do_enq    = in_valid && in_ready && !bypass;
    assign do_deq    = stored_valid && out_ready;
    assign count     = count_q;

    // Pointer and occupancy tracking; flush wins over any concurrent transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (do_enq) tail <= tail + PTR_W'(1);
            if (do_deq) head <= head + PTR_W'(1);
            case ({do_enq, do_deq})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_enq && !flush) mem[tail] <= in_ent;
    end

    // Head selection; zero when nothing is valid so outputs are clean after reset.
    always_comb begin
        head_ent = '0;
        if (bypass) begin
            head_ent = in_ent;
        end else if (stored_valid) begin
            head_ent = mem[head];
        end
    end

    assign out_pc           = head_ent.pc;
    assign out_inst         = head_ent.inst;
    assign out_pre_taken    = head_ent.pre_taken;
    assign out_pre_addr     = head_ent.pre_addr;
    assign out_is_exception = head_ent.is_exception;
    assign out_exc_cause    = head_ent.exc_cause;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a cycle table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_inst_fetch_queue;
    import ifq_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic                                   clk = 1'b0;
    logic                                   rst_n = 1'b0;
    logic                                   flush = 1'b0;
    logic                                   in_valid = 1'b0;
    logic                                   in_ready;
    logic [31:0]                            in_pc = '0;
    logic [31:0]                            in_inst = '0;
    logic                                   in_pre_taken = 1'b0;
    logic [31:0]                            in_pre_addr = '0;
    logic [EXC_FLAGS-1:0]                   in_is_exception = '0;
    logic [EXC_FLAGS-1:0][EXC_CAUSE_W-1:0]  in_exc_cause = '0;
    logic                                   out_valid;
    logic                                   out_ready = 1'b0;
    logic [31:0]                            out_pc;
    logic [31:0]                            out_inst;
    logic                                   out_pre_taken;
    logic [31:0]                            out_pre_addr;
    logic [EXC_FLAGS-1:0]                   out_is_exception;
    logic [EXC_FLAGS-1:0][EXC_CAUSE_W-1:0]  out_exc_cause;
    logic [3:0]                             count;

    int passes = 0;
    int total  = 0;

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_pre_taken(in_pre_taken),
        .in_pre_addr(in_pre_addr), .in_is_exception(in_is_exception),
        .in_exc_cause(in_exc_cause),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_pre_taken(out_pre_taken),
        .out_pre_addr(out_pre_addr), .out_is_exception(out_is_exception),
        .out_exc_cause(out_exc_cause), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Advance one cycle and land mid-low-phase, ready to drive and sample.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic fl, input logic iv, input logic ordy, input logic [31:0] pc);
        flush           = fl;
        in_valid        = iv;
        out_ready       = ordy;
        in_pc           = pc;
        in_inst         = ~pc;
        in_pre_taken    = pc[2];
        in_pre_addr     = pc + 32'h100;
        in_is_exception = pc[3:2];
        in_exc_cause    = {pc[10:4], pc[17:11]};
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic ifq_entry_t cur_in();
        return '{pc: in_pc, inst: in_inst, pre_taken: in_pre_taken, pre_addr: in_pre_addr,
                 is_exception: in_is_exception, exc_cause: in_exc_cause};
    endfunction

    function automatic ifq_entry_t cur_out();
        return '{pc: out_pc, inst: out_inst, pre_taken: out_pre_taken, pre_addr: out_pre_addr,
                 is_exception: out_is_exception, exc_cause: out_exc_cause};
    endfunction

    typedef struct {
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] pc;
        logic        ov;
        logic        ir;
        logic [3:0]  cnt;
        logic [31:0] opc;
    } vec_t;

    vec_t vt [11];
    ifq_entry_t mq [$];
    ifq_entry_t exp_ent;

    initial begin
        // Cycle table: inputs applied before an edge, outputs expected before that edge.
        vt[0]  = '{1'b0, 1'b1, 1'b0, 32'h1c00_0a00, 1'b0, 1'b1, 4'd0, 32'h0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 32'h1c00_0a04, 1'b1, 1'b1, 4'd1, 32'h1c00_0a00};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 32'h1c00_0a08, 1'b1, 1'b1, 4'd2, 32'h1c00_0a00};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 4'd2, 32'h1c00_0a04};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 4'd1, 32'h1c00_0a08};
        vt[5]  = '{1'b1, 1'b1, 1'b1, 32'h1c00_0a0c, 1'b1, 1'b1, 4'd1, 32'h1c00_0a08};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 4'd0, 32'h0};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 4'd0, 32'h0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 32'h1c00_0a10, 1'b0, 1'b1, 4'd0, 32'h0};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 4'd1, 32'h1c00_0a10};
        vt[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 4'd0, 32'h0};

        // Reset state
        #1;
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_data", 128'(cur_out()), 128'(0));
        do_reset();

        for (int i = 0; i < 11; i++) begin
            drive(vt[i].fl, vt[i].iv, vt[i].ordy, vt[i].pc);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), 128'(out_valid), 128'(vt[i].ov));
            chk($sformatf("tbl%0d_in_ready", i), 128'(in_ready), 128'(vt[i].ir));
            chk($sformatf("tbl%0d_count", i), 128'(count), 128'(vt[i].cnt));
            chk($sformatf("tbl%0d_out_pc", i), 128'(out_pc), 128'(vt[i].opc));
            step();
        end

        // 1: reset mid-stream
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h2000_0000 + 32'(i * 4));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        chk("mid_pre_count", 128'(count), 128'(5));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 128'(count), 128'(0));
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // 2/3: fill, full with simultaneous enq+deq, drain in order with wrap
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h1c00_0000 + 32'(i * 4));
            step();
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("fill_count", 128'(count), 128'(8));
        chk("fill_in_ready", 128'(in_ready), 128'(0));
        drive(1'b0, 1'b1, 1'b1, 32'h1c00_0020);
        #1;
        chk("full_sim_in_ready", 128'(in_ready), 128'(1));
        chk("full_sim_head", 128'(out_pc), 128'(32'h1c00_0000));
        step();
        drive(1'b0, 1'b0, 1'b1, '0);
        #1;
        chk("full_sim_count", 128'(count), 128'(8));
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d_pc", i), 128'(out_pc), 128'(32'h1c00_0000 + 32'(i * 4)));
            step();
        end
        chk("drain_empty", 128'(out_valid), 128'(0));

        // 4: flush vs concurrent enqueue
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h3000_0000 + 32'(i * 4));
            step();
        end
        drive(1'b1, 1'b1, 1'b0, 32'h3000_0100);
        #1;
        chk("flush_pre_count", 128'(count), 128'(3));
        step();
        drive(1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("flush_count", 128'(count), 128'(0));
        chk("flush_out_valid", 128'(out_valid), 128'(0));

        // 5: field integrity
        drive(1'b0, 1'b1, 1'b0, 32'h1c00_0080);
        in_inst = 32'hdead_beef;
        in_pre_taken = 1'b1;
        in_pre_addr = 32'h1c00_0100;
        in_is_exception = 2'b01;
        in_exc_cause = {7'h00, 7'h08};
        step();
        drive(1'b0, 1'b0, 1'b1, '0);
        #1;
        chk("fld_pc", 128'(out_pc), 128'(32'h1c00_0080));
        chk("fld_inst", 128'(out_inst), 128'(32'hdead_beef));
        chk("fld_pre_taken", 128'(out_pre_taken), 128'(1));
        chk("fld_pre_addr", 128'(out_pre_addr), 128'(32'h1c00_0100));
        chk("fld_is_exc", 128'(out_is_exception), 128'(2'b01));
        chk("fld_cause", 128'(out_exc_cause), 128'({7'h00, 7'h08}));
        step();
        drive(1'b0, 1'b0, 1'b0, '0);

        // 6: empty queue, producer and consumer both ready
        drive(1'b0, 1'b1, 1'b1, 32'h1c00_0040);
        #1;
`ifdef IFQ_BYPASS_EN
        chk("byp_out_valid", 128'(out_valid), 128'(1));
        chk("byp_out_pc", 128'(out_pc), 128'(32'h1c00_0040));
        step();
        drive(1'b0, 1'b0, 1'b0, '0);
        #1;
        chk("byp_count", 128'(count), 128'(0));
`else
        chk("nobyp_out_valid0", 128'(out_valid), 128'(0));
        step();
        drive(1'b0, 1'b0, 1'b1, '0);
        #1;
        chk("nobyp_out_valid1", 128'(out_valid), 128'(1));
        chk("nobyp_out_pc", 128'(out_pc), 128'(32'h1c00_0040));
        step();
        drive(1'b0, 1'b0, 1'b0, '0);
`endif

        // Randomized run against a queue model
        do_reset();
        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            logic fl, iv, ordy, byp, exp_ir, exp_ov;
            fl   = ($urandom_range(0, 31) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) == 0) ? 1'b0 : ($urandom_range(0, 1) == 1);
            drive(fl, iv, ordy, $urandom());
            in_inst         = $urandom();
            in_pre_taken    = 1'($urandom());
            in_is_exception = 2'($urandom());
            in_exc_cause    = 14'($urandom());
            #1;
`ifdef IFQ_BYPASS_EN
            byp = (mq.size() == 0) && iv && ordy && !fl;
`else
            byp = 1'b0;
`endif
            exp_ir  = (mq.size() != DEPTH) || (mq.size() != 0 && ordy);
            exp_ov  = (mq.size() != 0) || byp;
            exp_ent = byp ? cur_in() : ((mq.size() != 0) ? mq[0] : '0);
            chk("rnd_count", 128'(count), 128'(mq.size()));
            chk("rnd_in_ready", 128'(in_ready), 128'(exp_ir));
            chk("rnd_out_valid", 128'(out_valid), 128'(exp_ov));
            chk("rnd_entry", 128'(cur_out()), 128'(exp_ent));
            if (fl) begin
                mq.delete();
            end else if (!byp) begin
                if (mq.size() != 0 && ordy) void'(mq.pop_front());
                if (iv && exp_ir) mq.push_back(cur_in());
            end
            step();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
